// File: rtl/clock_divider.sv
// -----------------------------------------------------------------------------
// clock_divider
//
// Purpose
//   Produces a 50%-duty square wave at clk_FPGA / (2 * MAXIMUM_VALUE). A single
//   wrap-around counter marks out each half period, and a toggle flop flips the
//   output at the end of every half period. Intended to be fed directly by the
//   board oscillator and used as a low-rate tick or enable.
//
// Parameters
//   FREQUENCY          desired output frequency in Hz
//   REFERENCE_CLOCK    frequency of clk_FPGA in Hz
//   MAXIMUM_VALUE      half-period length in clk_FPGA cycles (truncated ratio)
//   NBITS_FOR_COUNTER  half-period counter width
//
// Ports
//   clk_FPGA      in   1  reference clock, all logic on its rising edge
//   reset         in   1  synchronous, active-high reset
//   clock_signal  out  1  divided clock, driven straight from a flop
// -----------------------------------------------------------------------------

package clock_divider_pkg;

    // Smallest n such that 2**n > x, so an n-bit counter can hold 0..x.
    // Examples: 5 -> 3, 4 -> 3, 1 -> 1.
    function automatic int ceil_log2(input int x);
        int n;
        n = 0;
        while ((64'd1 << n) <= 64'(x)) begin
            n++;
        end
        return n;
    endfunction

endpackage

module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int FREQUENCY         = 5_000_000,
    parameter int REFERENCE_CLOCK   = 50_000_000,
    parameter int MAXIMUM_VALUE     = (REFERENCE_CLOCK / FREQUENCY) / 2,
    parameter int NBITS_FOR_COUNTER = ceil_log2(MAXIMUM_VALUE)
) (
    input  logic clk_FPGA,
    input  logic reset,
    output logic clock_signal
);

    // -------------------------------------------------------------------------
    // Elaboration-time legality checks
    // -------------------------------------------------------------------------
    if (MAXIMUM_VALUE < 1) begin : g_bad_ratio
        $error("clock_divider: MAXIMUM_VALUE=%0d < 1 (FREQUENCY too high for REFERENCE_CLOCK)",
               MAXIMUM_VALUE);
    end

    if (NBITS_FOR_COUNTER < ceil_log2(MAXIMUM_VALUE)) begin : g_bad_width
        $error("clock_divider: NBITS_FOR_COUNTER=%0d too narrow for MAXIMUM_VALUE=%0d",
               NBITS_FOR_COUNTER, MAXIMUM_VALUE);
    end

    // -------------------------------------------------------------------------
    // Constants sized to the counter so the terminal compare uses full width
    // -------------------------------------------------------------------------
    localparam logic [NBITS_FOR_COUNTER-1:0] CountLast = NBITS_FOR_COUNTER'(MAXIMUM_VALUE - 1);
    localparam logic [NBITS_FOR_COUNTER-1:0] CountOne  = NBITS_FOR_COUNTER'(1);
    localparam logic [NBITS_FOR_COUNTER-1:0] CountZero = '0;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NBITS_FOR_COUNTER-1:0] count_q;
    logic [NBITS_FOR_COUNTER-1:0] count_d;
    logic                         clock_signal_q;
    logic                         clock_signal_d;
    logic                         half_period_done;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // The counter wraps at MAXIMUM_VALUE-1, so it can never reach 2**NBITS and
    // no overflow path exists.
    assign half_period_done = (count_q == CountLast);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        count_d        = count_q + CountOne;
        clock_signal_d = clock_signal_q;

        if (half_period_done) begin
            count_d        = CountZero;
            clock_signal_d = ~clock_signal_q;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // Reset is sampled only on the clock edge and takes priority over counting;
    // there is no partial-period memory across a reset.
    always_ff @(posedge clk_FPGA) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its input from before the edge, independent of statement order.
        if (reset) begin
            count_q        <= CountZero;
            clock_signal_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            clock_signal_q <= clock_signal_d;
        end
    end

    // Output comes straight from a flop, so it is glitch-free.
    assign clock_signal = clock_signal_q;

endmodule

// File: tb/tb_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_clock_divider
//
// Purpose
//   Self-checking bench for clock_divider. Three instances share one clock and
//   reset: defaults (half period 5), FREQUENCY=25 MHz (half period 1, 1-bit
//   counter) and FREQUENCY=3 MHz (truncated half period 8, 4-bit counter).
//   Expected values come from the closed form: k edges after reset release,
//   count = k mod M and clock_signal = (k / M) mod 2.
// -----------------------------------------------------------------------------

module tb_clock_divider;

    logic clk_fpga = 1'b0;
    logic reset    = 1'b1;
    logic out5;
    logic out1;
    logic out8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_fpga = ~clk_fpga;

    clock_divider dut5 (
        .clk_FPGA     (clk_fpga),
        .reset        (reset),
        .clock_signal (out5)
    );

    clock_divider #(.FREQUENCY(25_000_000)) dut1 (
        .clk_FPGA     (clk_fpga),
        .reset        (reset),
        .clock_signal (out1)
    );

    clock_divider #(.FREQUENCY(3_000_000)) dut8 (
        .clk_FPGA     (clk_fpga),
        .reset        (reset),
        .clock_signal (out8)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic tick();
        @(posedge clk_fpga);
        #1;
    endtask

    task automatic check_all(input string tag, input int k);
        check({tag, " out5"},  int'(out5),          (k / 5) % 2);
        check({tag, " cnt5"},  int'(dut5.count_q),  k % 5);
        check({tag, " out1"},  int'(out1),          k % 2);
        check({tag, " cnt1"},  int'(dut1.count_q),  0);
        check({tag, " out8"},  int'(out8),          (k / 8) % 2);
        check({tag, " cnt8"},  int'(dut8.count_q),  k % 8);
    endtask

    initial begin
        int rises5, rises1, rises8, high5, max_cnt5;
        logic p5, p1, p8;

        // ---------------- reset held for 3 edges ----------------
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("reset[%0d]", i), 0);
        end

        // ---------------- 40 edges after release ----------------
        reset  = 1'b0;
        rises5 = 0; rises1 = 0; rises8 = 0; high5 = 0;
        p5 = out5; p1 = out1; p8 = out8;
        for (int k = 1; k <= 40; k++) begin
            tick();
            check_all($sformatf("run[%0d]", k), k);
            if (out5 && !p5) rises5++;
            if (out1 && !p1) rises1++;
            if (out8 && !p8) rises8++;
            if (out5) high5++;
            p5 = out5; p1 = out1; p8 = out8;
        end
        check("run rises5", rises5, 4);
        check("run high5",  high5,  20);
        check("run rises1", rises1, 20);
        check("run rises8", rises8, 3);

        // ---------------- mid-run reset at edge 7 ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        check("mid pre out5", int'(out5),         1);
        check("mid pre cnt5", int'(dut5.count_q), 1);
        reset = 1'b1;
        tick();
        check("mid rst out5", int'(out5),         0);
        check("mid rst cnt5", int'(dut5.count_q), 0);
        check("mid rst out8", int'(out8),         0);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("mid rel[%0d] out5", k), int'(out5), (k == 5) ? 1 : 0);
        end

        // ---------------- long run: 10000 edges ----------------
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        rises5   = 0; rises1 = 0; rises8 = 0; max_cnt5 = 0;
        p5 = out5; p1 = out1; p8 = out8;
        for (int k = 1; k <= 10_000; k++) begin
            tick();
            if (out5 && !p5) rises5++;
            if (out1 && !p1) rises1++;
            if (out8 && !p8) rises8++;
            if (int'(dut5.count_q) > max_cnt5) max_cnt5 = int'(dut5.count_q);
            p5 = out5; p1 = out1; p8 = out8;
        end
        check("long rises5",  rises5,   1000);
        check("long maxcnt5", max_cnt5, 4);
        check("long rises1",  rises1,   5000);
        check("long rises8",  rises8,   625);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
